commit_arbiter: RTL and testbench

COMMIT_ARBITER -- requirements
Module: commit_arbiter

---
 rtl/commit_arbiter.sv | 127 ++++++++++++
 tb/tb_commit_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/commit_arbiter.sv
// Round-robin commit arbiter: picks one execution unit per cycle to retire,
// drives the register-file write port or an error report, and acknowledges the unit.

package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

module commit_arbiter
    import core_config_pkg::*;
#(
    parameter int N_UNITS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_UNITS-1:0][XLEN-1:0]           u_res,
    input  logic [N_UNITS-1:0][REG_ADDR_W-1:0]     u_rd,
    input  logic [N_UNITS-1:0]                     u_valid,
    input  logic [N_UNITS-1:0]                     u_error,
    input  logic [N_UNITS-1:0]                     u_req,
    output logic [N_UNITS-1:0]                     u_clear,
    input  logic                                   stall,
    output logic                                   rf_we,
    output logic [REG_ADDR_W-1:0]                  rf_waddr,
    output logic [XLEN-1:0]                        rf_wdata,
    output logic                                   exc_valid,
    output logic [REG_ADDR_W-1:0]                  exc_rd,
    output logic [$clog2(N_UNITS)-1:0]             exc_unit
);

    localparam int UNIT_W = $clog2(N_UNITS);

    logic [N_UNITS-1:0]    u_clear_q,   u_clear_d;
    logic [UNIT_W-1:0]     ptr_q,       ptr_d;
    logic                  rf_we_q,     rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q,  rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q,  rf_wdata_d;
    logic                  exc_valid_q, exc_valid_d;
    logic [REG_ADDR_W-1:0] exc_rd_q,    exc_rd_d;
    logic [UNIT_W-1:0]     exc_unit_q,  exc_unit_d;

    logic [N_UNITS-1:0]    eligible;
    logic                  grant_valid;
    logic [UNIT_W-1:0]     grant_idx;
    logic [UNIT_W-1:0]     cand_idx;
    int                    cand;

    // A unit whose clear is currently being driven is masked so it cannot be granted twice.
    always_comb begin
        eligible    = u_req & ~u_clear_q & {N_UNITS{~stall}};
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_UNITS) begin
                cand = cand - N_UNITS;
            end
            cand_idx = UNIT_W'(cand);
            if (!grant_valid && eligible[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        u_clear_d   = '0;
        ptr_d       = ptr_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        exc_valid_d = 1'b0;
        exc_rd_d    = exc_rd_q;
        exc_unit_d  = exc_unit_q;
        if (grant_valid) begin
            u_clear_d[grant_idx] = 1'b1;
            if (int'(grant_idx) == N_UNITS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
            // Error wins over valid; x0 destinations and retire-only grants write nothing.
            if (u_error[grant_idx]) begin
                exc_valid_d = 1'b1;
                exc_rd_d    = u_rd[grant_idx];
                exc_unit_d  = grant_idx;
            end else if (u_valid[grant_idx] && (u_rd[grant_idx] != '0)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = u_rd[grant_idx];
                rf_wdata_d = u_res[grant_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_clear_q   <= '0;
            ptr_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            exc_valid_q <= 1'b0;
            exc_rd_q    <= '0;
            exc_unit_q  <= '0;
        end else begin
            u_clear_q   <= u_clear_d;
            ptr_q       <= ptr_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            exc_valid_q <= exc_valid_d;
            exc_rd_q    <= exc_rd_d;
            exc_unit_q  <= exc_unit_d;
        end
    end

    assign u_clear   = u_clear_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign exc_valid = exc_valid_q;
    assign exc_rd    = exc_rd_q;
    assign exc_unit  = exc_unit_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed bench for commit_arbiter: a vector table for single-cycle behaviour
// plus hand-written contention, stall and mid-stream reset sequences.

module tb_commit_arbiter;

    logic              clk;
    logic              rst_n;
    logic [3:0][31:0]  u_res;
    logic [3:0][4:0]   u_rd;
    logic [3:0]        u_valid;
    logic [3:0]        u_error;
    logic [3:0]        u_req;
    logic [3:0]        u_clear;
    logic              stall;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              exc_valid;
    logic [4:0]        exc_rd;
    logic [1:0]        exc_unit;

    int passCount = 0;
    int totalCount = 0;

    commit_arbiter #(.N_UNITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .u_res     (u_res),
        .u_rd      (u_rd),
        .u_valid   (u_valid),
        .u_error   (u_error),
        .u_req     (u_req),
        .u_clear   (u_clear),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .exc_valid (exc_valid),
        .exc_rd    (exc_rd),
        .exc_unit  (exc_unit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  valid;
        logic [3:0]  error;
        logic        stl;
        logic [3:0]  expClear;
        logic        expWe;
        logic [4:0]  expWaddr;
        logic [31:0] expWdata;
        logic        expExc;
        logic [4:0]  expExcRd;
        logic [1:0]  expExcUnit;
    } vec_t;

    vec_t vecs[10];

    task automatic checkField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eClear, input logic eWe,
                               input logic [4:0] eWaddr, input logic [31:0] eWdata,
                               input logic eExc, input logic [4:0] eExcRd, input logic [1:0] eExcUnit);
        checkField(name, "u_clear",   32'(u_clear),   32'(eClear));
        checkField(name, "rf_we",     32'(rf_we),     32'(eWe));
        checkField(name, "rf_waddr",  32'(rf_waddr),  32'(eWaddr));
        checkField(name, "rf_wdata",  rf_wdata,       eWdata);
        checkField(name, "exc_valid", 32'(exc_valid), 32'(eExc));
        checkField(name, "exc_rd",    32'(exc_rd),    32'(eExcRd));
        checkField(name, "exc_unit",  32'(exc_unit),  32'(eExcUnit));
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] valid,
                                 input logic [3:0] error, input logic stl);
        u_req   = req;
        u_valid = valid;
        u_error = error;
        stall   = stl;
    endtask

    // Asserts reset without a clock edge, checks the cleared outputs, then releases.
    task automatic resetDut(input string name);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput(name, 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'd0);
        @(posedge clk);
        #1;
        checkOutput({name, "_held"}, 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'd0);
        rst_n = 1'b1;
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rotClear[6];
    logic       rotWe[6];

    initial begin
        u_rd  = {5'd13, 5'd5, 5'd7, 5'd0};
        u_res = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;

        //          req      valid    error    stl  clear    we  waddr  wdata         exc rd    unit
        vecs[0] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 2'd0};
        vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 2'd0};
        vecs[2] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 2'd1};
        vecs[3] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd7, 2'd1};
        vecs[4] = '{4'b1001, 4'b0001, 4'b0000, 1'b0, 4'b1000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd7, 2'd1};
        vecs[5] = '{4'b1001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd7, 2'd1};
        vecs[6] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd7, 2'd1};
        vecs[7] = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd7, 2'd1};
        vecs[8] = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 5'd7, 32'h11111111, 1'b0, 5'd7, 2'd1};
        vecs[9] = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 5'd7, 32'h11111111, 1'b0, 5'd7, 2'd1};

        #1;
        resetDut("reset");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].req, vecs[i].valid, vecs[i].error, vecs[i].stl);
            stepCycle();
            checkOutput($sformatf("vec%0d", i), vecs[i].expClear, vecs[i].expWe, vecs[i].expWaddr,
                        vecs[i].expWdata, vecs[i].expExc, vecs[i].expExcRd, vecs[i].expExcUnit);
        end

        // Units 0,1,3 contend continuously from pointer 0: rotation 0,1,3,0,1,3.
        resetDut("reset_contention");
        rotClear = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        rotWe    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        applyStimulus(4'b1011, 4'b1011, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            checkField($sformatf("contend%0d", i), "u_clear", 32'(u_clear), 32'(rotClear[i]));
            checkField($sformatf("contend%0d", i), "rf_we",   32'(rf_we),   32'(rotWe[i]));
        end

        // All units request; stall for three cycles after the first grant.
        resetDut("reset_stall");
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0);
        stepCycle();
        checkField("stall_pre", "u_clear", 32'(u_clear), 32'(4'b0001));
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkField($sformatf("stall%0d", i), "u_clear", 32'(u_clear), 32'(4'b0000));
            checkField($sformatf("stall%0d", i), "rf_we",   32'(rf_we),   32'(1'b0));
        end
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0);
        stepCycle();
        checkOutput("stall_resume", 4'b0010, 1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 2'd0);
        stepCycle();
        checkOutput("stall_next", 4'b0100, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 2'd0);

        // Full rotation 0..3, then reset while unit 3's clear is high.
        resetDut("reset_midstream");
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkField($sformatf("rotate%0d", i), "u_clear", 32'(u_clear), 32'(4'b0001 << i));
        end
        checkOutput("before_reset", 4'b1000, 1'b1, 5'd13, 32'h33333333, 1'b0, 5'd0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'd0);
        applyStimulus(4'b0110, 4'b0110, 4'b0000, 1'b0);
        #2;
        rst_n = 1'b1;
        stepCycle();
        checkOutput("after_reset", 4'b0010, 1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 2'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
